// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: D = A - B over WIDTH cycles, start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the two's-complement overflow output V.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             V,
`endif
  output logic             BOUT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic             br;
  logic [CW-1:0]    cnt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             a_msb, b_msb;
`endif

  // Full-subtractor cell on the current LSBs.
  logic             a0, b0, dbit, bnext;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    a0      = a_sr[0];
    b0      = b_sr[0];
    dbit    = a0 ^ b0 ^ br;
    bnext   = (~a0 & b0) | (~(a0 ^ b0) & br);
    res_nxt = {dbit, r_sr[WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      D     <= '0;
      BOUT  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      V     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: begin
          DONE <= 1'b0;
          if (START) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
            BUSY  <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= res_nxt;
          br   <= bnext;
          cnt  <= cnt + CW'(1);
          // Final shift: publish result together with the last borrow.
          if (cnt == LAST) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            D     <= res_nxt;
            BOUT  <= bnext;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            V     <= (a_msb != b_msb) && (dbit != a_msb);
`endif
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks for serial_subtractor at WIDTH=4.
// Covers the optional V output when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST_N, START, BUSY, DONE, BOUT;
  logic [W-1:0] A, B, D;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         V;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .D     (D),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .V     (V),
`endif
    .BOUT  (BOUT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // One full operation from IDLE; checks latency, hold of D, result and single DONE.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ed, input logic eb);
    logic [3:0] held;
    int         k;
    A = a; B = b; START = 1'b1;
    step;
    START = 1'b0;
    A = ~a; B = ~b;
    chk("busy_after_accept", BUSY, 1);
    held = D;
    k = 0;
    while (k < 20) begin
      step;
      k++;
      if (DONE) break;
      chk("d_hold", D, held);
    end
    chk("latency", k, 4);
    chk("d", D, ed);
    chk("bout", BOUT, eb);
    chk("busy_fin", BUSY, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("v_model", V, (a[3] != b[3]) && (ed[3] != a[3]));
`endif
    step;
    chk("done_single", DONE, 0);
    chk("d_after", D, ed);
  endtask

  initial begin
    int k;
    int n_done;
    int ha[4] = '{8, 9, 2, 15};
    int hb[4] = '{8, 3, 7, 1};
    int hd[4] = '{0, 6, 11, 14};
    int hbo[4] = '{0, 0, 1, 0};

    // 1: reset state and first op
    RST_N = 1'b0; START = 1'b0; A = '0; B = '0;
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_d", D, 0);
    chk("rst_bout", BOUT, 0);
    #21 RST_N = 1'b1;
    step;
    chk("idle_busy", BUSY, 0);
    run_op(4'd9, 4'd3, 4'd6, 1'b0);

    // 2: borrow and wrap cases
    run_op(4'd3, 4'd9, 4'hA, 1'b1);
    run_op(4'd0, 4'd1, 4'hF, 1'b1);
    run_op(4'd5, 4'd5, 4'h0, 1'b0);

    // 3: START during busy is ignored
    A = 4'd9; B = 4'd3; START = 1'b1;
    step;
    START = 1'b0;
    step;
    A = 4'd1; B = 4'd1; START = 1'b1;
    step;
    START = 1'b0;
    k = 0;
    while (k < 20) begin
      if (DONE) break;
      step;
      k++;
    end
    chk("ign_done_seen", DONE, 1);
    chk("ign_d", D, 6);
    chk("ign_bout", BOUT, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (DONE) n_done++;
    end
    chk("ign_no_extra_done", n_done, 0);
    chk("ign_idle", BUSY, 0);

    // 3b: START held high -> back-to-back ops every 5 cycles
    A = 4'(ha[0]); B = 4'(hb[0]); START = 1'b1;
    step;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (k < 20) begin
        step;
        k++;
        if (DONE) break;
      end
      chk("hold_latency", k, 4);
      chk("hold_d", D, hd[i]);
      chk("hold_bout", BOUT, hbo[i]);
      if (i < 3) begin
        A = 4'(ha[i+1]); B = 4'(hb[i+1]);
      end else begin
        START = 1'b0;
      end
      step;
      chk("hold_busy", BUSY, (i < 3) ? 1 : 0);
    end

    // 4: async reset mid-shift aborts
    A = 4'd12; B = 4'd4; START = 1'b1;
    step;
    START = 1'b0;
    step;
    step;
    chk("pre_rst_busy", BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_d", D, 0);
    chk("abort_bout", BOUT, 0);
    #3 RST_N = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (DONE) n_done++;
      chk("abort_d_stays0", D, 0);
    end
    chk("abort_no_done", n_done, 0);
    run_op(4'd12, 4'd4, 4'd8, 1'b0);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // 5: overflow flag
    run_op(4'd7, 4'd8, 4'hF, 1'b1);
    chk("ovf_7_m8", V, 1);
    run_op(4'd3, 4'd1, 4'd2, 1'b0);
    chk("ovf_3_1", V, 0);
`endif

    // 6: exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 4'(a - b), (a < b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
